frame_assembler: RTL
====================

# frame_assembler

Receive-side counterpart of the cipher load sequencer. It consumes the 10-bit key and data word stream, framed by `kctr`/`dctr`, and reassembles the 40-bit key and 20-bit data block. It then times the processing window until `save`, and hands the captured 20-bit result downstream over a valid/ready handshake. It sits between the sequencer outputs and the cipher core or result sink, and flags framing errors and timeouts.

## Interface
- `DATAW`, 10, word width; key is 4·DATAW, data and result are 2·DATAW.
- `TIMEOUT`, 40, maximum cycles from frame completion to `save` (must be ≥ 32).
- `clk`  input  1  clock; all sampling on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `kctr`  input  1  key word strobe.
- `dctr`  input  1  data word strobe.
- `keyin`  input  DATAW  key word, sampled when `kctr`=1.
- `datain`  input  DATAW  data word, sampled when `dctr`=1.
- `save`  input  1  processing-done strobe from the sequencer.
- `result_in`  input  2·DATAW  core output, sampled when `save` rises.
- `key`  output  4·DATAW  assembled key, K0 in bits [DATAW-1:0].
- `data`  output  2·DATAW  assembled data, D0 in the low word.
- `frame_valid`  output  1  one-cycle pulse when the frame completes.
- `frame_err`  output  1  one-cycle pulse on a bad frame.
- `timeout`  output  1  one-cycle pulse when `save` is missing.
- `result`  output  2·DATAW  captured result.
- `result_valid`  output  1  result pending.
- `result_ready`  input  1  downstream accept.
- `overflow`  output  1  sticky; set when a result is dropped, cleared only by `rst`.

## Operation
- Load FSM has three states: IDLE, LOAD and WAIT.
- IDLE → LOAD on the first cycle with `kctr`=1; that word is stored as K0 and `kcnt` is set to 1.
- LOAD, key path: each `kctr`=1 cycle stores `keyin` to slot `kcnt`, then increments `kcnt`.
  - Once `kcnt`=4, further `kctr` beats are ignored when `keyin` equals K3.
  - Any other excess key beat marks the frame bad.
- LOAD, data path: the same rule applies to `dctr`/`datain` with `dcnt`, limit 2; a repeat equal to D1 is ignored.
- LOAD ends on the first cycle with `kctr`=0 and `dctr`=0.
  - Counts 4/2 and no bad mark: pulse `frame_valid` next cycle, `key`/`data` hold stable, go to WAIT and clear the window counter.
  - Otherwise: pulse `frame_err`, go to IDLE; `key`/`data` are unchanged from the previous good frame.
- WAIT:
  - Window counter increments each cycle.
  - Rising edge of `save` (1 now, 0 last cycle) captures the result, then returns to IDLE.
  - If `kctr`=1 on the same cycle, go directly to LOAD with that word as K0 (back-to-back frames).
  - Counter reaching `TIMEOUT` without `save`: pulse `timeout`, go to IDLE, capture nothing.
- `save` rising edge outside WAIT is ignored.
- Result buffer is one entry.
  - Capture sets `result_valid`, and `result` holds `result_in`.
  - A transfer occurs when `result_valid` and `result_ready` are both 1; `result_valid` then clears next cycle unless a new capture coincides, in which case the new result is loaded and valid stays 1.
  - A capture while valid=1 and ready=0 drops the new result, keeps the old one, and sets `overflow`.
- Reset values: state IDLE; counters 0; `key`, `data`, `result` all zero; every pulse output, `result_valid` and `overflow` 0. A reset mid-frame discards partial words.

## Timing
- All outputs are registered.
- `frame_valid` and `frame_err` rise one cycle after the first cycle with both strobes low.
- `result` and `result_valid` appear one cycle after the `save` rising edge.
- Nominal sequencer frame: 5 `kctr` cycles (K3 repeated) and 3 `dctr` cycles (D1 repeated) → `frame_valid` 6 cycles after the first `kctr`.
- Nominal `save` arrives 32 cycles after the strobes drop, which is within `TIMEOUT`.

## Structure
- Shared package holds the state encodings IDLE/LOAD/WAIT (2-bit), the key/data slot counts (4, 2), and the default `DATAW`.
- One sub-module, `result_buffer`: a single-entry valid/ready register with overflow detection.

## Test plan
- Nominal frame, then `save` after 32 cycles.
  - Stimulus: key 0x001, 0x002, 0x003, 0x004 (K3 repeated); data 0x0AA, 0x155 (D1 repeated).
  - Response: `key` = 0x004_003_002_001 (hex words), `data` = 0x155_0AA, one `frame_valid`, then `result_valid` with the `result_in` value.
- Frame with only 3 key beats → `frame_err`; `key`/`data` keep the previous frame's values.
- Excess key beat with a value different from K3 → `frame_err`.
- No `save` within 40 cycles → `timeout` pulse; `result_valid` stays 0.
- `result_ready` held 0 across two frames → first result retained, `overflow`=1; then `ready`=1 → one transfer.
- Assert `rst` mid-LOAD, then send a nominal frame → correct assembly, no `frame_err`.

Source files
------------

// File: rtl/frame_assembler_pkg.sv
// Shared definitions for the frame assembler: load FSM encoding,
// key/data slot counts and the default word width.
package frame_assembler_pkg;

  localparam int DEFAULT_DATAW = 10;
  localparam int KEY_SLOTS     = 4;
  localparam int DATA_SLOTS    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/frame_assembler_result_buffer.sv
// Single-entry result register with a valid/ready output port.
//
// Handshake: valid_o stays high while an entry is held; a transfer happens on
// every rising clk edge where valid_o and ready_i are both 1. A capture that
// coincides with a transfer replaces the entry and keeps valid_o high. A
// capture while the entry is held and not being transferred is dropped, and the
// sticky overflow_o flag is raised (cleared only by rst).
module result_buffer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overflow_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         overflow_q;

  // Load on capture when the slot is free or being drained, else flag the drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (capture_i) begin
      if (!valid_q || ready_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else begin
        overflow_q <= 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/frame_assembler.sv
// Receive-side frame assembler: rebuilds the 4-word key and 2-word data block
// from the kctr/dctr word stream, times the window until save, and hands the
// captured result downstream through a one-entry buffer.
//
// Window timing: the counter is 0 on the first WAIT cycle. A save rising edge
// on WAIT cycles 0..TIMEOUT-1 captures; otherwise timeout pulses on the cycle
// after WAIT cycle TIMEOUT-1.
module frame_assembler
  import frame_assembler_pkg::*;
#(
  parameter int DATAW   = DEFAULT_DATAW,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kctr,
  input  logic               dctr,
  input  logic [DATAW-1:0]   keyin,
  input  logic [DATAW-1:0]   datain,
  input  logic               save,
  input  logic [2*DATAW-1:0] result_in,
  output logic [4*DATAW-1:0] key,
  output logic [2*DATAW-1:0] data,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               timeout,
  output logic [2*DATAW-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               overflow,
  output logic [1:0]         state_dbg_o
);

  localparam int WINW = $clog2(TIMEOUT + 1);

  state_e                              state_q, state_d;
  logic [2:0]                          kcnt_q, kcnt_d;
  logic [1:0]                          dcnt_q, dcnt_d;
  logic                                bad_q, bad_d;
  logic [KEY_SLOTS-1:0][DATAW-1:0]     kbuf_q, kbuf_d;
  logic [DATA_SLOTS-1:0][DATAW-1:0]    dbuf_q, dbuf_d;
  logic [KEY_SLOTS-1:0][DATAW-1:0]     key_q, key_d;
  logic [DATA_SLOTS-1:0][DATAW-1:0]    data_q, data_d;
  logic [WINW-1:0]                     win_q, win_d;
  logic                                save_q;
  logic                                fv_q, fv_d;
  logic                                fe_q, fe_d;
  logic                                to_q, to_d;
  logic                                save_rise;
  logic                                capture;

  assign save_rise = save & ~save_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kcnt_q  <= '0;
      dcnt_q  <= '0;
      bad_q   <= 1'b0;
      kbuf_q  <= '0;
      dbuf_q  <= '0;
      key_q   <= '0;
      data_q  <= '0;
      win_q   <= '0;
      save_q  <= 1'b0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      dcnt_q  <= dcnt_d;
      bad_q   <= bad_d;
      kbuf_q  <= kbuf_d;
      dbuf_q  <= dbuf_d;
      key_q   <= key_d;
      data_q  <= data_d;
      win_q   <= win_d;
      save_q  <= save;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      to_q    <= to_d;
    end
  end

  // Load FSM: word slotting, frame checks, save window and timeout.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    dcnt_d  = dcnt_q;
    bad_d   = bad_q;
    kbuf_d  = kbuf_q;
    dbuf_d  = dbuf_q;
    key_d   = key_q;
    data_d  = data_q;
    win_d   = win_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    to_d    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kctr) begin
          kbuf_d[0] = keyin;
          kcnt_d    = 3'd1;
          dcnt_d    = 2'd0;
          bad_d     = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!kctr && !dctr) begin
          if (kcnt_q == 3'(KEY_SLOTS) && dcnt_q == 2'(DATA_SLOTS) && !bad_q) begin
            fv_d    = 1'b1;
            key_d   = kbuf_q;
            data_d  = dbuf_q;
            win_d   = '0;
            state_d = ST_WAIT;
          end else begin
            // Published key/data keep the last good frame.
            fe_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          if (kctr) begin
            if (kcnt_q < 3'(KEY_SLOTS)) begin
              kbuf_d[kcnt_q[1:0]] = keyin;
              kcnt_d              = kcnt_q + 3'd1;
            end else if (keyin != kbuf_q[KEY_SLOTS-1]) begin
              // Repeats of K3 are the sequencer's hold beat; anything else is bad.
              bad_d = 1'b1;
            end
          end
          if (dctr) begin
            if (dcnt_q < 2'(DATA_SLOTS)) begin
              dbuf_d[dcnt_q[0]] = datain;
              dcnt_d            = dcnt_q + 2'd1;
            end else if (datain != dbuf_q[DATA_SLOTS-1]) begin
              bad_d = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        win_d = win_q + WINW'(1);
        if (save_rise) begin
          capture = 1'b1;
          if (kctr) begin
            // Back-to-back frame: this beat is already K0 of the next one.
            kbuf_d[0] = keyin;
            kcnt_d    = 3'd1;
            dcnt_d    = 2'd0;
            bad_d     = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (win_q == WINW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  result_buffer #(
    .W (2*DATAW)
  ) u_result_buffer (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .data_i     (result_in),
    .ready_i    (result_ready),
    .data_o     (result),
    .valid_o    (result_valid),
    .overflow_o (overflow)
  );

  assign key         = key_q;
  assign data        = data_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign timeout     = to_q;
  assign state_dbg_o = state_q;

endmodule
